// File: rtl/hazard_controller_if.sv
// Hazard controller handshake bundle: decode-stage hazard info and memory/branch status toward the
// controller, pipeline-register enables, flushes and ALU forwarding selects back to the datapath.
interface hazard_controller_if #(
    parameter int unsigned REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_wr_reg;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             ex_branch_taken;
    logic             mem_ack;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_req;
    logic             mem_err;

    // Datapath side: presents decode info and memory/branch status, consumes controls.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_wr_reg, id_regwrite, id_memread, id_memwrite,
        output ex_branch_taken, mem_ack,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        input  fwd_a, fwd_b, mem_req, mem_err
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_wr_reg, id_regwrite, id_memread, id_memwrite,
        input  ex_branch_taken, mem_ack,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        output fwd_a, fwd_b, mem_req, mem_err
    );
endinterface

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard controller: shadow EX/MEM/WB tracking, memory-wait stall, branch flush,
// load-use stall and ALU forwarding. Define HAZARD_FORWARDING_EN to enable forwarding; otherwise RAW stalls.
module hazard_controller #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave hif
);
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
    } shadow_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    shadow_t          ex_q, mem_q, wb_q;
    shadow_t          id_c;

    logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c, memwb_en_c;
    logic       mem_req_c, mem_op_c, mem_stall_c, load_use_c, data_stall_c;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       unused_shadow;

    // True when stage s holds a real destination that the decode instruction reads.
    function automatic logic reads_dest(input shadow_t s, input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rt, input logic uses_rt);
        return s.valid && (s.rd != '0) && ((s.rd == rs) || (uses_rt && (s.rd == rt)));
    endfunction

    always_comb begin
        id_c          = '0;
        id_c.valid    = hif.id_valid;
        id_c.rs       = hif.id_rs;
        id_c.rt       = hif.id_rt;
        id_c.rd       = hif.id_wr_reg;
        id_c.regwrite = hif.id_regwrite;
        id_c.memread  = hif.id_memread;
        id_c.memwrite = hif.id_memwrite;
    end

    assign mem_op_c   = mem_q.valid && (mem_q.memread || mem_q.memwrite);
    assign load_use_c = hif.id_valid && ex_q.memread
                        && reads_dest(ex_q, hif.id_rs, hif.id_rt, hif.id_uses_rt);

`ifdef HAZARD_FORWARDING_EN
    // EX/MEM result wins over MEM/WB; a bubble in EX never forwards.
    function automatic logic [1:0] fwd_sel(input shadow_t e, input shadow_t m, input shadow_t w,
                                           input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (e.valid) begin
            if (m.valid && m.regwrite && (m.rd != '0) && (m.rd == src)) begin
                sel = 2'b10;
            end else if (w.valid && w.regwrite && (w.rd != '0) && (w.rd == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a_c      = rst ? fwd_sel(ex_q, mem_q, wb_q, ex_q.rs) : 2'b00;
    assign fwd_b_c      = rst ? fwd_sel(ex_q, mem_q, wb_q, ex_q.rt) : 2'b00;
    assign data_stall_c = load_use_c;
`else
    logic raw_c;

    // Without forwarding, any in-flight writer of a decode source holds decode until it retires.
    assign raw_c = hif.id_valid
                   && ((ex_q.regwrite  && reads_dest(ex_q,  hif.id_rs, hif.id_rt, hif.id_uses_rt))
                    || (mem_q.regwrite && reads_dest(mem_q, hif.id_rs, hif.id_rt, hif.id_uses_rt))
                    || (wb_q.regwrite  && reads_dest(wb_q,  hif.id_rs, hif.id_rt, hif.id_uses_rt)));

    assign fwd_a_c      = 2'b00;
    assign fwd_b_c      = 2'b00;
    assign data_stall_c = load_use_c || raw_c;
`endif

    // Next state and control outputs; a memory stall overrides branch and data hazards.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_stall_c  = 1'b0;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b1;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        mem_req_c    = mem_op_c;

        case (state_q)
            RUN: begin
                if (mem_op_c && !hif.mem_ack) begin
                    mem_stall_c = 1'b1;
                    state_d     = MEM_WAIT;
                    cnt_d       = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hif.mem_ack || (cnt_q == CNT_W'(MEM_TIMEOUT))) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (!hif.mem_ack) begin
                        err_d = 1'b1;
                    end
                end else begin
                    mem_stall_c = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        // The release cycle falls through to normal priority so a held branch or load-use is honoured.
        if (mem_stall_c) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else if (hif.ex_branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (data_stall_c) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
        end

        if (!rst) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            ifid_flush_c = 1'b1;
            idex_en_c    = 1'b0;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b0;
            memwb_en_c   = 1'b0;
            mem_req_c    = 1'b0;
        end
    end

    // State register and shadow pipeline; shadows move in lockstep with EX/MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (exmem_en_c) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= (idex_en_c && !idex_flush_c) ? id_c : '0;
            end
        end
    end

    assign unused_shadow = ^{ex_q, mem_q, wb_q};

    assign hif.pc_en      = pc_en_c;
    assign hif.ifid_en    = ifid_en_c;
    assign hif.ifid_flush = ifid_flush_c;
    assign hif.idex_en    = idex_en_c;
    assign hif.idex_flush = idex_flush_c;
    assign hif.exmem_en   = exmem_en_c;
    assign hif.memwb_en   = memwb_en_c;
    assign hif.fwd_a      = fwd_a_c;
    assign hif.fwd_b      = fwd_b_c;
    assign hif.mem_req    = mem_req_c;
    assign hif.mem_err    = err_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: instruction-level pipeline model compared every cycle, directed
// sequences with literal expectations, then randomized traffic including resets and memory timeouts.
`timescale 1ns/1ps
module tb_hazard_controller;
    localparam int unsigned REG_W = 5;
    localparam int TO = 15;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct {
        bit v;
        int rs, rt, rd;
        bit ut, rw, mr, mw;
    } ins_t;

    typedef struct {
        bit pc, ifid, ifidf, idex, idexf, exmem, memwb, req, err;
        int fa, fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; waited = stall cycles spent on the current access.
    ins_t pipe [3];
    int   waited = 0;
    bit   err = 1'b0;

    always #5 clk = ~clk;

    hazard_controller_if #(.REG_W(REG_W)) hif ();

    hazard_controller #(.REG_W(REG_W), .MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    task automatic cmp(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic ins_t cur_id();
        ins_t i;
        i.v  = hif.id_valid;
        i.rs = int'(hif.id_rs);
        i.rt = int'(hif.id_rt);
        i.rd = int'(hif.id_wr_reg);
        i.ut = hif.id_uses_rt;
        i.rw = hif.id_regwrite;
        i.mr = hif.id_memread;
        i.mw = hif.id_memwrite;
        return i;
    endfunction

    function automatic bit dep(input ins_t s, input ins_t id);
        return s.v && (s.rd != 0) && ((s.rd == id.rs) || (id.ut && (s.rd == id.rt)));
    endfunction

    function automatic int fwd_for(input int src);
        if (!FWD_ON || !pipe[0].v) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].rw && (pipe[k].rd != 0) && (pipe[k].rd == src))
                return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        ins_t id;
        bit   memop, lu, raw;
        id    = cur_id();
        memop = pipe[1].v && (pipe[1].mr || pipe[1].mw);
        lu    = id.v && pipe[0].mr && dep(pipe[0], id);
        raw   = 1'b0;
        for (int k = 0; k < 3; k++) raw = raw || (id.v && pipe[k].rw && dep(pipe[k], id));
        e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1; e.memwb = 1;
        e.ifidf = 0; e.idexf = 0;
        e.req = memop;
        e.err = err;
        e.fa  = fwd_for(pipe[0].rs);
        e.fb  = fwd_for(pipe[0].rt);
        if (memop && !hif.mem_ack && (waited != TO)) begin
            e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
        end else if (hif.ex_branch_taken) begin
            e.ifidf = 1; e.idexf = 1;
        end else if (lu || (!FWD_ON && raw)) begin
            e.pc = 0; e.ifid = 0; e.idexf = 1;
        end
        if (!rst) begin
            e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0; e.memwb = 0;
            e.ifidf = 1; e.idexf = 1; e.fa = 0; e.fb = 0; e.req = 0;
        end
        return e;
    endfunction

    // Model advance on the same edge as the DUT.
    always @(posedge clk) begin
        exp_t e;
        bit   memop;
        e     = predict();
        memop = pipe[1].v && (pipe[1].mr || pipe[1].mw);
        if (!rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
            waited = 0;
            err    = 1'b0;
        end else if (!e.exmem) begin
            waited++;
        end else begin
            if (memop && !hif.mem_ack && (waited == TO)) err = 1'b1;
            waited  = 0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e.idex && !e.idexf) pipe[0] = cur_id();
            else                    pipe[0] = '{default: 0};
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        e = predict();
        cmp("pc_en",      int'(hif.pc_en),      int'(e.pc));
        cmp("ifid_en",    int'(hif.ifid_en),    int'(e.ifid));
        cmp("ifid_flush", int'(hif.ifid_flush), int'(e.ifidf));
        cmp("idex_en",    int'(hif.idex_en),    int'(e.idex));
        cmp("idex_flush", int'(hif.idex_flush), int'(e.idexf));
        cmp("exmem_en",   int'(hif.exmem_en),   int'(e.exmem));
        cmp("memwb_en",   int'(hif.memwb_en),   int'(e.memwb));
        cmp("fwd_a",      int'(hif.fwd_a),      e.fa);
        cmp("fwd_b",      int'(hif.fwd_b),      e.fb);
        cmp("mem_req",    int'(hif.mem_req),    int'(e.req));
        cmp("mem_err",    int'(hif.mem_err),    int'(e.err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit ut,
                          input int wr, input bit rw, input bit mr, input bit mw);
        hif.id_valid    = v;
        hif.id_rs       = REG_W'(rs);
        hif.id_rt       = REG_W'(rt);
        hif.id_uses_rt  = ut;
        hif.id_wr_reg   = REG_W'(wr);
        hif.id_regwrite = rw;
        hif.id_memread  = mr;
        hif.id_memwrite = mw;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        nop();
        repeat (n) tick();
    endtask

    initial begin
        int deaf;
        int kind;
        nop();
        hif.ex_branch_taken = 1'b0;
        hif.mem_ack         = 1'b0;
        rst = 1'b0;
        tick();

        // Reset held three cycles, then released with an empty decode stage.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp("lit_rst_pc_en", int'(hif.pc_en), 0);
            cmp("lit_rst_ifid_flush", int'(hif.ifid_flush), 1);
            cmp("lit_rst_exmem_en", int'(hif.exmem_en), 0);
            cmp("lit_rst_mem_req", int'(hif.mem_req), 0);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        cmp("lit_rel_pc_en", int'(hif.pc_en), 1);
        cmp("lit_rel_memwb_en", int'(hif.memwb_en), 1);
        cmp("lit_rel_idex_flush", int'(hif.idex_flush), 0);
        cmp("lit_rel_fwd_a", int'(hif.fwd_a), 0);
        cmp("lit_rel_mem_err", int'(hif.mem_err), 0);
        tick();

        // ADD r3,r1,r2 then SUB r4,r3,r5 back to back.
        set_id(1, 1, 2, 1, 3, 1, 0, 0);
        @(negedge clk); cmp("lit_add_issue", int'(hif.pc_en), 1); tick();
        set_id(1, 3, 5, 1, 4, 1, 0, 0);
`ifdef HAZARD_FORWARDING_EN
        @(negedge clk); cmp("lit_sub_nostall", int'(hif.pc_en), 1); tick();
        nop();
        @(negedge clk);
        cmp("lit_fwd_a_exmem", int'(hif.fwd_a), 2);
        cmp("lit_fwd_b_none", int'(hif.fwd_b), 0);
        tick();
        idle(4);
        // Same pair with one NOP between: MEM/WB forwarding.
        set_id(1, 1, 2, 1, 3, 1, 0, 0); @(negedge clk); tick();
        nop(); @(negedge clk); tick();
        set_id(1, 3, 5, 1, 4, 1, 0, 0);
        @(negedge clk); cmp("lit_sub2_nostall", int'(hif.pc_en), 1); tick();
        nop();
        @(negedge clk); cmp("lit_fwd_a_memwb", int'(hif.fwd_a), 1); tick();
`else
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmp("lit_raw_stall_pc", int'(hif.pc_en), 0);
            cmp("lit_raw_stall_flush", int'(hif.idex_flush), 1);
            tick();
        end
        @(negedge clk); cmp("lit_raw_issue_pc", int'(hif.pc_en), 1); tick();
`endif
        idle(4);

        // LW r2,0(r1) then ADD r6,r2,r1 with an always-ready memory.
        hif.mem_ack = 1'b1;
        set_id(1, 1, 0, 0, 2, 1, 1, 0);
        @(negedge clk); tick();
        set_id(1, 2, 1, 1, 6, 1, 0, 0);
        @(negedge clk);
        cmp("lit_lu_pc_en", int'(hif.pc_en), 0);
        cmp("lit_lu_ifid_en", int'(hif.ifid_en), 0);
        cmp("lit_lu_idex_flush", int'(hif.idex_flush), 1);
        cmp("lit_lu_exmem_en", int'(hif.exmem_en), 1);
        tick();
`ifdef HAZARD_FORWARDING_EN
        @(negedge clk); cmp("lit_lu_resume", int'(hif.pc_en), 1); tick();
        nop();
        @(negedge clk); cmp("lit_lu_fwd_a", int'(hif.fwd_a), 1); tick();
`else
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); cmp("lit_lu_raw_stall", int'(hif.pc_en), 0); tick();
        end
        @(negedge clk); cmp("lit_lu_issue", int'(hif.pc_en), 1); tick();
`endif
        hif.mem_ack = 1'b0;
        idle(4);

        // SW reaches MEM, ack four cycles late, branch raised mid-wait.
        set_id(1, 1, 2, 1, 0, 0, 0, 1);
        @(negedge clk); tick();
        nop(); @(negedge clk); tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) hif.ex_branch_taken = 1'b1;
            @(negedge clk);
            cmp("lit_sw_req", int'(hif.mem_req), 1);
            cmp("lit_sw_pc_en", int'(hif.pc_en), 0);
            cmp("lit_sw_memwb_en", int'(hif.memwb_en), 0);
            cmp("lit_sw_ifid_flush", int'(hif.ifid_flush), 0);
            tick();
        end
        hif.mem_ack = 1'b1;
        @(negedge clk);
        cmp("lit_sw_ack_req", int'(hif.mem_req), 1);
        cmp("lit_sw_ack_exmem", int'(hif.exmem_en), 1);
        cmp("lit_sw_ack_ifid_flush", int'(hif.ifid_flush), 1);
        cmp("lit_sw_ack_idex_flush", int'(hif.idex_flush), 1);
        tick();
        hif.mem_ack = 1'b0;
        hif.ex_branch_taken = 1'b0;
        @(negedge clk); cmp("lit_sw_done_req", int'(hif.mem_req), 0); tick();
        idle(3);

        // LW r7 with no ack: forced release after TO stall cycles, sticky error.
        set_id(1, 0, 0, 0, 7, 1, 1, 0);
        @(negedge clk); tick();
        nop(); @(negedge clk); tick();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            cmp("lit_to_stall", int'(hif.pc_en), 0);
            cmp("lit_to_req", int'(hif.mem_req), 1);
            tick();
        end
        @(negedge clk);
        cmp("lit_to_release", int'(hif.pc_en), 1);
        cmp("lit_to_err_pending", int'(hif.mem_err), 0);
        tick();
        @(negedge clk);
        cmp("lit_to_err_set", int'(hif.mem_err), 1);
        cmp("lit_to_req_off", int'(hif.mem_req), 0);
        tick();
        idle(5);
        @(negedge clk); cmp("lit_to_err_sticky", int'(hif.mem_err), 1); tick();
        rst = 1'b0;
        @(negedge clk); tick();
        rst = 1'b1;
        @(negedge clk); cmp("lit_to_err_cleared", int'(hif.mem_err), 0); tick();

        // Branch and load-use in the same cycle: flush wins.
        hif.mem_ack = 1'b1;
        set_id(1, 1, 0, 0, 2, 1, 1, 0);
        @(negedge clk); tick();
        set_id(1, 2, 1, 1, 6, 1, 0, 0);
        hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        cmp("lit_bl_ifid_flush", int'(hif.ifid_flush), 1);
        cmp("lit_bl_idex_flush", int'(hif.idex_flush), 1);
        cmp("lit_bl_pc_en", int'(hif.pc_en), 1);
        cmp("lit_bl_ifid_en", int'(hif.ifid_en), 1);
        tick();
        hif.ex_branch_taken = 1'b0;
        idle(4);
        hif.mem_ack = 1'b0;

        // Randomized traffic on a small register set, with occasional resets and deaf memory.
        deaf = 0;
        repeat (4000) begin
            rst = ($urandom_range(0, 199) != 0);
            kind = int'($urandom_range(0, 9));
            if (kind < 2)
                set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3), 0,
                       $urandom_range(0, 3), 1, 1, 0);
            else if (kind == 2)
                set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3), 1,
                       $urandom_range(0, 3), 0, 0, 1);
            else
                set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                       $urandom_range(0, 9) < 8, 0, 0);
            hif.ex_branch_taken = ($urandom_range(0, 11) == 0);
            if (deaf > 0) begin
                hif.mem_ack = 1'b0;
                deaf--;
            end else begin
                hif.mem_ack = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 299) == 0) deaf = 25;
            end
            tick();
        end

        rst = 1'b1;
        hif.ex_branch_taken = 1'b0;
        hif.mem_ack = 1'b1;
        idle(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Sequencing controller for the 5-stage pipeline datapath (IF/ID, ID/EX, EX/MEM, MEM/WB registers, ALU, data memory). It keeps its own shadow copy of the destination and control bits of each in-flight instruction. From these it generates the pipeline-register enables, flushes and ALU forwarding selects. It stalls the whole pipeline while a data-memory access is outstanding.

Parameters:
REG_W, 5, register address width
MEM_TIMEOUT, 15, max cycles to wait for mem_ack before forced release (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
id_valid  in  1  decode stage holds a real instruction
id_rs  in  REG_W  source register A of decode instruction
id_rt  in  REG_W  source register B of decode instruction
id_uses_rt  in  1  decode instruction reads rt (R-type, store, branch)
id_wr_reg  in  REG_W  destination (RegDst already applied)
id_regwrite  in  1  WB RegWrite of decode instruction
id_memread  in  1  decode instruction is a load
id_memwrite  in  1  decode instruction is a store
ex_branch_taken  in  1  EX stage resolved branch taken (Branch & zero)
mem_ack  in  1  data memory completes current access
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to bubble
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX load bubble (all control zero)
exmem_en  out  1  EX/MEM load enable
memwb_en  out  1  MEM/WB load enable
fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  same for operand B
mem_req  out  1  data-memory access request
mem_err  out  1  sticky timeout flag

Behaviour:
- Shadow stages EX, MEM, WB each hold: valid, rs, rt, rd, regwrite, memread, memwrite. They advance on every clock when exmem_en=1. ID goes to EX when idex_en=1 and idex_flush=0. Otherwise EX receives a bubble (valid=0).
- rd=0 never matches. Invalid stages never match.
- Outputs are combinational from state, shadow registers and inputs. Registered state updates on the rising edge.
- FSM states:
  - RUN: default.
  - MEM_WAIT: MEM shadow is valid with memread|memwrite and mem_ack is not yet seen.
  - Entry: on the cycle a load/store enters MEM, mem_req=1. If mem_ack=1 in that same cycle, there is no stall and the FSM stays in RUN. Otherwise it goes to MEM_WAIT.
  - MEM_WAIT outputs: mem_req=1; pc_en, ifid_en, idex_en, exmem_en, memwb_en all 0; flushes 0; a pending ex_branch_taken is ignored (held).
  - Exit: on mem_ack=1, return to RUN with all enables 1 in that cycle.
  - Timeout: a counter counts MEM_WAIT cycles. At MEM_TIMEOUT cycles without ack, set mem_err=1 (sticky until reset) and exit as if acked. The counter clears on exit.
- RUN priority, highest first:
  1. Branch taken: ex_branch_taken=1 gives ifid_flush=1 and idex_flush=1. All enables stay 1. Penalty is 2 bubbles. Load-use in the same cycle is discarded.
  2. Load-use: EX memread & EX rd matches id_rs (or id_rt when id_uses_rt) & id_valid. Then pc_en=0, ifid_en=0, idex_flush=1, others 1. Exactly 1 bubble; the next cycle re-evaluates.
  3. Otherwise all enables 1, flushes 0.
- Forwarding (EX-stage operands vs MEM/WB shadows):
  - fwd_a=10 if MEM regwrite & MEM rd==EX rs; else 01 if WB regwrite & WB rd==EX rs; else 00.
  - EX/MEM wins when both match. fwd_b uses the same rule against EX rt.
- Reset while rst=0, and on the first cycle after release:
  - all shadow valid=0, FSM=RUN, counter=0, mem_err=0;
  - outputs while rst=0: pc_en=0, all stage enables 0, ifid_flush=1, idex_flush=1, fwd_a=fwd_b=00, mem_req=0.
  - Reset during MEM_WAIT aborts the access immediately (mem_req=0 that cycle).

Optional Feature:
Macro HAZARD_FORWARDING_EN.
- Defined: forwarding as above; only load-use stalls.
- Undefined: fwd_a/fwd_b tied to 00. Any ID source matching a valid regwrite destination in EX, MEM or WB causes a stall (pc_en=0, ifid_en=0, idex_flush=1), repeated until no match. Branch and MEM_WAIT priority are unchanged.

Test Plan:
- Reset held 3 cycles, then released, with id_valid=0: all enables 1, fwd=00, mem_req=0, mem_err=0.
- ADD r3 then SUB r4,r3,r5 back-to-back (forwarding on): SUB in EX gives fwd_a=10, no stall. With one NOP between them: fwd_a=01.
- LW r2 then ADD r6,r2,r1: exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle fwd_a=01, no further stall.
- SW in MEM, mem_ack delayed 4 cycles: mem_req=1 for 5 cycles, all enables 0 for 4 cycles, resume on ack. A branch_taken asserted mid-wait flushes only after resume.
- mem_ack never arrives, MEM_TIMEOUT=15: after 15 stall cycles mem_err=1 and the pipeline resumes. A later reset clears mem_err.
- With HAZARD_FORWARDING_EN undefined, ADD r3 then SUB r4,r3,r5: three stall cycles (r3 in EX, MEM, WB), then issue. Simultaneous branch_taken and load-use: flush wins, no stall.
